// File: rtl/srl_fifo_read_ctrl.sv
// Read-side controller and storage for a shift-register FIFO with a registered show-ahead
// output stage; capacity is DEPTH words in the SRL plus one in the output register.
module srl_fifo_read_ctrl #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [CNT_W-1:0]      count_q, count_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  vld_q, vld_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  full_n_q, full_n_d;
   logic [CNT_W-1:0]      num_q, num_d;
   logic [DATA_WIDTH-1:0] srl_q [DEPTH];
   logic [DATA_WIDTH-1:0] head;
   logic                  push, pop, load;

   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read & if_read_ce & vld_q;
   assign load = (count_q != '0) & (~vld_q | pop);

   // Oldest SRL word, selected by the read pointer
   always_comb begin
      head = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ptr_q == ADDR_WIDTH'(i)) head = srl_q[i];
      end
   end

   // Next-state for count, pointer, output stage and the registered status flags
   always_comb begin
      count_d = count_q;
      ptr_d   = ptr_q;
      vld_d   = vld_q;
      dout_d  = dout_q;
      case ({push, load})
         2'b10: begin
            count_d = count_q + CNT_W'(1);
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
         end
         2'b01: begin
            count_d = count_q - CNT_W'(1);
            ptr_d   = ptr_q - ADDR_WIDTH'(1);
         end
         default: ;
      endcase
      if (load) begin
         dout_d = head;
         vld_d  = 1'b1;
      end else if (pop) begin
         vld_d  = 1'b0;
      end
      full_n_d = (count_d != CNT_W'(DEPTH));
      num_d    = count_d + CNT_W'(vld_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         ptr_q    <= '1;
         vld_q    <= 1'b0;
         dout_q   <= '0;
         full_n_q <= 1'b1;
         num_q    <= '0;
      end else begin
         count_q  <= count_d;
         ptr_q    <= ptr_d;
         vld_q    <= vld_d;
         dout_q   <= dout_d;
         full_n_q <= full_n_d;
         num_q    <= num_d;
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (push) begin
         srl_q[0] <= if_din;
         for (int unsigned i = 1; i < DEPTH; i++) srl_q[i] <= srl_q[i-1];
      end
   end

   assign if_full_n         = full_n_q;
   assign if_dout           = dout_q;
   assign if_empty_n        = vld_q;
   assign if_num_data_valid = num_q;

endmodule
